// File: rtl/dsp_chain_pkg.sv
// -----------------------------------------------------------------------------
// dsp_chain_pkg
//   Shared constants and types for the fp16 sum-of-products DSP chain and its
//   result drain.
//
//   FP32_W / FP16_W : word widths of chain results and chain operands
//   fp32_t          : one fp32 chain result word
//   CHAIN_LATENCY   : issue-to-result latency of the standard 4-stage chain
// -----------------------------------------------------------------------------
package dsp_chain_pkg;

  localparam int FP32_W        = 32;
  localparam int FP16_W        = 16;
  localparam int CHAIN_LATENCY = 4;

  typedef logic [FP32_W-1:0] fp32_t;

endpackage : dsp_chain_pkg

// File: rtl/dsp_drain_fifo.sv
// -----------------------------------------------------------------------------
// dsp_drain_fifo
//   DEPTH x DATA_W result buffer with registered pointers and occupancy.
//   Write and read pointers wrap modulo DEPTH (DEPTH is a power of two).
//   flush is synchronous and outranks any write or read in the same cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   flush     in   discard all buffered entries, pointers back to 0
//   wr_en     in   write wr_data at the next edge
//   wr_data   in   DATA_W word to store
//   rd_ready  in   consumer takes rd_data this cycle
//   rd_valid  out  at least one entry buffered
//   rd_data   out  oldest entry (zero while empty)
//   level     out  number of buffered entries, 0..DEPTH
// -----------------------------------------------------------------------------
module dsp_drain_fifo
  import dsp_chain_pkg::*;
#(
  parameter int DATA_W = FP32_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign rd_valid = (level != '0);
  assign push     = wr_en & ~flush;
  assign pop      = rd_valid & rd_ready & ~flush;

  // Empty reads return zero so the output word is clean straight out of reset
  // without the storage array itself needing a reset.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is carried by
  // level/pointers, and a reset on the array would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // The issue credits upstream make a write into a full buffer impossible;
  // if one ever happens a result would be silently overwritten.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop && level == (PTR_W+1)'(DEPTH)))
    else $fatal(1, "dsp_drain_fifo: write into full buffer");

endmodule : dsp_drain_fifo

// File: rtl/dsp_chain_result_drain.sv
// -----------------------------------------------------------------------------
// dsp_chain_result_drain
//   Receive side of the fp16 sum-of-products DSP chain. Every accepted issue
//   drops a token into a LATENCY-deep shift register; when the token leaves the
//   register the chain result of that issue is on chain_result and is written
//   into the result FIFO. issue_ready grants a new issue only while the results
//   already in flight plus those buffered leave a free FIFO slot, so the chain
//   can never produce a result with nowhere to go.
//
// Build option
//   DSP_DRAIN_STATS_EN : adds stat_results (pop count) and stat_stalls (cycles
//                        with issue_valid & !issue_ready); both wrap and are
//                        cleared by reset and flush.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   issue_valid   in   operand set presented to the chain this cycle
//   issue_ready   out  a result slot is reserved for a new issue
//   chain_result  in   output of the last chain stage
//   flush         in   synchronous discard of in-flight and buffered results
//   out_valid     out  out_data holds a buffered result
//   out_ready     in   downstream accepts out_data
//   out_data      out  oldest buffered result
//   level         out  FIFO occupancy (in-flight results excluded)
//   stat_results  out  [DSP_DRAIN_STATS_EN] results handed downstream
//   stat_stalls   out  [DSP_DRAIN_STATS_EN] issue cycles refused for credit
// -----------------------------------------------------------------------------
module dsp_chain_result_drain
  import dsp_chain_pkg::*;
#(
  parameter int DATA_W  = FP32_W,
  parameter int LATENCY = CHAIN_LATENCY,  // 1..16
  parameter int DEPTH   = 8               // power of two, >= 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [DATA_W-1:0]      chain_result,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level
`ifdef DSP_DRAIN_STATS_EN
  ,
  output logic [31:0]            stat_results,
  output logic [31:0]            stat_stalls
`endif
);

  localparam int IF_W = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] tok_q;        // one bit per pipeline stage of the chain
  logic [IF_W-1:0]    inflight_q;   // population count of tok_q, kept as a counter
  logic               issue_acc;
  logic               capture;
  logic [31:0]        credits_used;

  // The oldest token reaches the end of the register exactly when its result
  // is on chain_result, so the capture happens LATENCY edges after the issue.
  assign capture = tok_q[LATENCY-1];

  // Built from registers only: no combinational path from issue_valid or
  // out_ready to issue_ready.
  assign credits_used = 32'(inflight_q) + 32'(level);
  assign issue_ready  = credits_used < 32'(DEPTH);

  assign issue_acc = issue_valid & issue_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok_q      <= '0;
      inflight_q <= '0;
    end else if (flush) begin
      tok_q      <= '0;
      inflight_q <= '0;
    end else begin
      // Shift toward the MSB; the cast drops the token that is being captured.
      tok_q      <= LATENCY'({tok_q, issue_acc});
      inflight_q <= inflight_q + IF_W'(issue_acc) - IF_W'(capture);
    end
  end

  // A capture coincident with flush is discarded inside the FIFO.
  dsp_drain_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .flush    (flush),
    .wr_en    (capture),
    .wr_data  (chain_result),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .level    (level)
  );

`ifdef DSP_DRAIN_STATS_EN
  logic pop;

  // Pops coincident with flush are dropped and therefore not counted.
  assign pop = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_results <= '0;
      stat_stalls  <= '0;
    end else if (flush) begin
      stat_results <= '0;
      stat_stalls  <= '0;
    end else begin
      if (pop)                        stat_results <= stat_results + 32'd1;
      if (issue_valid && !issue_ready) stat_stalls  <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule : dsp_chain_result_drain

// File: tb/tb_dsp_chain_result_drain.sv
// -----------------------------------------------------------------------------
// tb_dsp_chain_result_drain
//   Directed bench for dsp_chain_result_drain with LATENCY=4, DEPTH=8.
//   A behavioural chain delays issue_data by LATENCY edges onto chain_result.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dsp_chain_result_drain;
  import dsp_chain_pkg::*;

  localparam int DATA_W  = FP32_W;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic             issue_ready;
  fp32_t            issue_data;
  fp32_t            chain_result;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  fp32_t            out_data;
  logic [LVL_W-1:0] level;
`ifdef DSP_DRAIN_STATS_EN
  logic [31:0]      stat_results;
  logic [31:0]      stat_stalls;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fp32_t pipe [LATENCY];

  always #5 clk = ~clk;

  // Chain model: the operand value present at edge k appears on chain_result
  // during the cycle that ends with edge k+LATENCY.
  always @(posedge clk) begin
    #1;
    for (int i = LATENCY - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0]      = issue_data;
    chain_result = pipe[LATENCY-1];
  end

  dsp_chain_result_drain #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .chain_result (chain_result),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level)
`ifdef DSP_DRAIN_STATS_EN
    ,
    .stat_results (stat_results),
    .stat_stalls  (stat_stalls)
`endif
  );

  task automatic test_reset();
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_data  = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    chain_result = '0;
    for (int i = 0; i < LATENCY; i++) pipe[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
    tests_run++;
    if (level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
  endtask

  task automatic test_single();
    int early;
    early = 0;
    issue_valid = 1'b1;
    issue_data  = 32'h3F80_0000;
    @(negedge clk);                       // issue edge k passed
    issue_valid = 1'b0;
    issue_data  = '0;
    for (int i = 1; i < LATENCY; i++) begin
      @(negedge clk);                     // edges k+1 .. k+3
      if (out_valid !== 1'b0 || level !== 4'd0) early++;
    end
    tests_run++;
    if (early !== 0) begin tests_failed++; $display("FAIL single_early: got %0d early cycles want 0", early); end
    @(negedge clk);                       // edge k+4: captured
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    tests_run++;
    if (out_data !== 32'h3F80_0000) begin tests_failed++; $display("FAIL single_out_data: got %h want 3f800000", out_data); end
    tests_run++;
    if (level !== 4'd1) begin tests_failed++; $display("FAIL single_level: got %0d want 1", level); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      tests_failed++; $display("FAIL single_pop: got valid=%b level=%0d want valid=0 level=0", out_valid, level);
    end
  endtask

  task automatic test_back_to_back();
    int    accepted;
    fp32_t nxt;
    accepted  = 0;
    nxt       = 32'hA000_0000;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      issue_valid = 1'b1;
      issue_data  = nxt;
      if (issue_ready) begin accepted++; nxt = nxt + 32'd1; end
      @(negedge clk);
    end
    issue_valid = 1'b0;
    tests_run++;
    if (accepted !== 8) begin tests_failed++; $display("FAIL b2b_accepted: got %0d want 8", accepted); end
    repeat (LATENCY) @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_low: got %b want 0", issue_ready); end
    tests_run++;
    if (level !== 4'd8) begin tests_failed++; $display("FAIL b2b_level_full: got %0d want 8", level); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'hA000_0000 + 32'(i)) begin
        tests_failed++;
        $display("FAIL b2b_order[%0d]: got valid=%b data=%h want valid=1 data=%h",
                 i, out_valid, out_data, 32'hA000_0000 + 32'(i));
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    tests_run++;
    if (level !== 4'd0) begin tests_failed++; $display("FAIL b2b_drained: got %0d want 0", level); end
  endtask

  task automatic test_full_stream();
    fp32_t nxt;
    fp32_t exp;
    int    pops;
    int    bad_level;
    nxt = 32'hB000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      issue_valid = 1'b1;
      issue_data  = nxt;
      if (issue_ready) nxt = nxt + 32'd1;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    repeat (LATENCY + 1) @(negedge clk);
    tests_run++;
    if (level !== 4'd8) begin tests_failed++; $display("FAIL stream_fill: got %0d want 8", level); end
    // Full with no credit left: one pop frees a credit, after which every
    // cycle issues, captures and pops; occupancy settles at DEPTH-1-LATENCY.
    exp       = 32'hB000_0000;
    pops      = 0;
    bad_level = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      issue_valid = 1'b1;
      issue_data  = nxt;
      if (issue_ready) nxt = nxt + 32'd1;
      if (out_valid) begin
        tests_run++;
        if (out_data !== exp) begin
          tests_failed++; $display("FAIL stream_data[%0d]: got %h want %h", pops, out_data, exp);
        end
        exp = exp + 32'd1;
        pops++;
      end
      if (c >= 6 && level !== 4'd3) bad_level++;
      @(negedge clk);
    end
    tests_run++;
    if (pops !== 24) begin tests_failed++; $display("FAIL stream_rate: got %0d pops want 24", pops); end
    tests_run++;
    if (bad_level !== 0) begin tests_failed++; $display("FAIL stream_level: got %0d cycles off level 3 want 0", bad_level); end
    issue_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        tests_run++;
        if (out_data !== exp) begin
          tests_failed++; $display("FAIL stream_drain_data: got %h want %h", out_data, exp);
        end
        exp = exp + 32'd1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    tests_run++;
    if (exp !== nxt) begin tests_failed++; $display("FAIL stream_all_delivered: got next %h want %h", exp, nxt); end
    tests_run++;
    if (level !== 4'd0) begin tests_failed++; $display("FAIL stream_empty: got %0d want 0", level); end
  endtask

  task automatic test_flush();
    int seen;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_data  = 32'hE000_0000 + 32'(i);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    repeat (LATENCY + 1) @(negedge clk);
    tests_run++;
    if (level !== 4'd3) begin tests_failed++; $display("FAIL flush_pre_level: got %0d want 3", level); end
    for (int i = 3; i < 5; i++) begin
      issue_valid = 1'b1;
      issue_data  = 32'hE000_0000 + 32'(i);
      @(negedge clk);
    end
    // Flush with two results in flight; the coincident issue and pop are dropped.
    issue_data = 32'hE000_0099;
    flush      = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    issue_valid = 1'b0;
    tests_run++;
    if (level !== 4'd0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_clear: got level=%0d valid=%b want level=0 valid=0", level, out_valid);
    end
    tests_run++;
    if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %b want 1", issue_ready); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL flush_inflight_dropped: got %0d outputs want 0", seen); end
    out_ready   = 1'b0;
    issue_valid = 1'b1;
    issue_data  = 32'hE000_0005;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (LATENCY) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'hE000_0005 || level !== 4'd1) begin
      tests_failed++;
      $display("FAIL flush_recover: got valid=%b data=%h level=%0d want valid=1 data=e0000005 level=1",
               out_valid, out_data, level);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue_valid = 1'b1;
      issue_data  = 32'hF000_0000 + 32'(i);
      @(negedge clk);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    tests_run++;
    if (level !== 4'd3 || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL areset_pre: got level=%0d valid=%b want level=3 valid=1", level, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || level !== 4'd0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got valid=%b data=%h level=%0d want 0/00000000/0", out_valid, out_data, level);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_ready: got %b want 1", issue_ready); end
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL areset_discard: got %0d outputs want 0", seen); end
  endtask

`ifdef DSP_DRAIN_STATS_EN
  task automatic test_stats();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (stat_results !== 32'd0 || stat_stalls !== 32'd0) begin
      tests_failed++; $display("FAIL stats_start: got results=%0d stalls=%0d want 0/0", stat_results, stat_stalls);
    end
    out_ready = 1'b0;
    // 8 accepted issues, then 5 cycles refused for lack of credit.
    for (int i = 0; i < 13; i++) begin
      issue_valid = 1'b1;
      issue_data  = 32'h5000_0000 + 32'(i);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    repeat (LATENCY + 1) @(negedge clk);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1'b1;
      issue_data  = 32'h5100_0000 + 32'(i);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    repeat (LATENCY + 1) @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (stat_results !== 32'd10) begin tests_failed++; $display("FAIL stats_results: got %0d want 10", stat_results); end
    tests_run++;
    if (stat_stalls !== 32'd5) begin tests_failed++; $display("FAIL stats_stalls: got %0d want 5", stat_stalls); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (stat_results !== 32'd0 || stat_stalls !== 32'd0) begin
      tests_failed++; $display("FAIL stats_flush: got results=%0d stalls=%0d want 0/0", stat_results, stat_stalls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stream();
    test_flush();
    test_async_reset();
`ifdef DSP_DRAIN_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dsp_chain_result_drain
